// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-add/full-subtract cell, LSB first,
// WIDTH cycles per operation behind a start/ready/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             mode_reg, mode_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;

  logic             a_bit, b_bit, s_bit, carry_new, last_bit;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] shifted;

  assign a_bit    = a_reg[cnt_reg];
  assign b_bit    = b_reg[cnt_reg];
  assign a_msb    = a_reg[WIDTH-1];
  assign b_msb    = b_reg[WIDTH-1];
  assign s_bit    = a_bit ^ b_bit ^ carry_reg;
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign carry_new = mode_reg ? ((~a_bit & b_bit) | (~(a_bit ^ b_bit) & carry_reg))
                              : ((a_bit & b_bit) | (carry_reg & (a_bit ^ b_bit)));

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
    assign shifted[gi] = work_reg[gi+1];
  end
  assign shifted[WIDTH-1] = s_bit;

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    mode_next   = mode_reg;
    carry_next  = carry_reg;
    cnt_next    = cnt_reg;
    work_next   = work_reg;
    result_next = result_reg;
    cout_next   = cout_reg;
    ovf_next    = ovf_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          mode_next  = mode;
          carry_next = 1'b0;
          cnt_next   = '0;
          work_next  = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        carry_next = carry_new;
        work_next  = shifted;
        cnt_next   = cnt_reg + CW'(1);
        if (last_bit) begin
          state_next  = IDLE;
          cnt_next    = '0;
          result_next = shifted;
          cout_next   = carry_new;
          ovf_next    = mode_reg ? ((a_msb != b_msb) && (s_bit != a_msb))
                                 : ((a_msb == b_msb) && (s_bit != a_msb));
          done_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      mode_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      work_reg   <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      mode_reg   <= mode_next;
      carry_reg  <= carry_next;
      cnt_reg    <= cnt_next;
      work_reg   <= work_next;
      result_reg <= result_next;
      cout_reg   <= cout_next;
      ovf_reg    <= ovf_next;
      done_reg   <= done_next;
    end
  end

  assign ready     = (state_reg == IDLE);
  assign busy      = ~ready;
  assign done      = done_reg;
  assign result    = result_reg;
  assign cout_bout = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboarded bench for serial_addsub: directed WIDTH=8 cases plus an
// exhaustive WIDTH=2 sweep against a whole-word arithmetic model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, mode;
  logic [7:0] a, b, result;
  logic       ready, busy, done, cout_bout, ovf;

  logic       start2, mode2;
  logic [1:0] a2, b2, result2;
  logic       ready2, busy2, done2, cout2, ovf2;

  serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .cout_bout(cout_bout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2),
    .ready(ready2), .busy(busy2), .done(done2), .result(result2),
    .cout_bout(cout2), .ovf(ovf2)
  );

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       o;
    int         e0;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] hold_r  = '0;
  logic       hold_c  = 1'b0, hold_o  = 1'b0, done_prev  = 1'b0;
  logic [1:0] hold2_r = '0;
  logic       hold2_c = 1'b0, hold2_o = 1'b0, done2_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input logic m, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic c, output logic o);
    logic [63:0] mask, full;
    mask = (64'd1 << w) - 64'd1;
    if (!m) begin
      full = x + y;
      c    = full[w];
    end else begin
      full = x - y;
      c    = (x < y);
    end
    r = full & mask;
    o = m ? ((x[w-1] != y[w-1]) && (r[w-1] != x[w-1]))
          : ((x[w-1] == y[w-1]) && (r[w-1] != x[w-1]));
  endfunction

  // WIDTH=8 scoreboard side
  always @(negedge clk) begin
    exp_t e;
    chk("busy8_vs_ready8", {63'b0, busy}, {63'b0, ~ready});
    if (done) begin
      chk("done8_single_cycle", {63'b0, done_prev}, 64'd0);
      chk("ready8_in_done", {63'b0, ready}, 64'd1);
      if (q8.size() == 0) begin
        chk("done8_without_op", {63'b0, done}, 64'd0);
      end else begin
        e = q8.pop_front();
        chk("result8", {56'b0, result}, {56'b0, e.r});
        chk("cout8", {63'b0, cout_bout}, {63'b0, e.c});
        chk("ovf8", {63'b0, ovf}, {63'b0, e.o});
        chk("latency8", 64'(cyc), 64'(e.e0 + 8));
        hold_r = e.r;
        hold_c = e.c;
        hold_o = e.o;
      end
    end else begin
      chk("result8_stable", {56'b0, result}, {56'b0, hold_r});
      chk("flags8_stable", {62'b0, cout_bout, ovf}, {62'b0, hold_c, hold_o});
    end
    done_prev = done;
  end

  // WIDTH=2 scoreboard side
  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        chk("done2_without_op", {63'b0, done2}, 64'd0);
      end else begin
        e = q2.pop_front();
        chk("result2", {62'b0, result2}, {56'b0, e.r});
        chk("cout2", {63'b0, cout2}, {63'b0, e.c});
        chk("ovf2", {63'b0, ovf2}, {63'b0, e.o});
        chk("latency2", 64'(cyc), 64'(e.e0 + 2));
        hold2_r = e.r[1:0];
        hold2_c = e.c;
        hold2_o = e.o;
      end
    end else begin
      chk("result2_stable", {61'b0, result2, cout2}, {61'b0, hold2_r, hold2_c});
    end
    done2_prev = done2;
  end

  task automatic issue8(input logic m, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] r, input logic c, input logic o, input bit accept);
    exp_t e;
    start = 1'b1; mode = m; a = x; b = y;
    if (accept) begin
      e = '{r: r, c: c, o: o, e0: cyc + 1};
      q8.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic issue8m(input logic m, input logic [7:0] x, input logic [7:0] y);
    logic [63:0] r;
    logic c, o;
    model(8, m, {56'b0, x}, {56'b0, y}, r, c, o);
    issue8(m, x, y, r[7:0], c, o, 1'b1);
  endtask

  task automatic issue2(input logic m, input logic [1:0] x, input logic [1:0] y);
    logic [63:0] r;
    logic c, o;
    exp_t e;
    model(2, m, {62'b0, x}, {62'b0, y}, r, c, o);
    start2 = 1'b1; mode2 = m; a2 = x; b2 = y;
    e = '{r: r[7:0], c: c, o: o, e0: cyc + 1};
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0; mode2 = ~m; a2 = ~x; b2 = ~y;
  endtask

  task automatic wait_done8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) chk("timeout8", {63'b0, done}, 64'd1);
  endtask

  task automatic wait_done2();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done2 && n < 20);
    if (!done2) chk("timeout2", {63'b0, done2}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    // start held high during reset must not be accepted
    rst = 1'b1; start = 1'b1; mode = 1'b0; a = 8'h11; b = 8'h22;
    start2 = 1'b1; mode2 = 1'b0; a2 = 2'd1; b2 = 2'd1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0; start2 = 1'b0;
    @(negedge clk);
    chk("reset_ready", {63'b0, ready}, 64'd1);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_result", {56'b0, result}, 64'd0);
    chk("reset_flags", {62'b0, cout_bout, ovf}, 64'd0);

    issue8(1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1); wait_done8();
    issue8(1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1); wait_done8();
    issue8(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1); wait_done8();
    issue8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1); wait_done8();
    issue8(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1); wait_done8();

    // start while busy is ignored; the following back-to-back start is taken
    @(posedge clk); #1;
    issue8(1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    issue8(1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0);
    wait_done8();
    issue8m(1'b0, 8'hC3, 8'h5A);
    wait_done8();

    // reset in the middle of a run aborts it
    @(posedge clk); #1;
    issue8(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q8.delete();
    hold_r = '0; hold_c = 1'b0; hold_o = 1'b0;
    @(negedge clk);
    chk("abort_ready", {63'b0, ready}, 64'd1);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_result", {56'b0, result}, 64'd0);
    chk("abort_flags", {62'b0, cout_bout, ovf}, 64'd0);
    issue8m(1'b1, 8'h34, 8'h12);
    wait_done8();

    for (int i = 0; i < 6; i++) begin
      issue8m(1'($urandom), 8'($urandom), 8'($urandom));
      wait_done8();
    end

    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          issue2(1'(m), 2'(x), 2'(y));
          wait_done2();
        end
      end
    end

    repeat (12) @(negedge clk);
    chk("pending8_drained", 64'(q8.size()), 64'd0);
    chk("pending2_drained", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. It is the sequential successor to the single-bit half/full subtractor cells. It latches two WIDTH-bit operands and a mode, then processes one bit per clock, LSB first, through a single full-add/full-subtract cell with a registered carry/borrow. It reports the result, the final carry/borrow and signed overflow through a start/ready/done handshake. It is used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request a new operation; sampled only while ready=1.
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
ready  output  1  1 when idle and able to accept start.
busy  output  1  1 while the serial operation is in progress; always equal to ~ready.
done  output  1  one-cycle pulse when result and flags become valid.
result  output  WIDTH  sum or difference; held until the next operation completes.
cout_bout  output  1  final carry-out (add) or final borrow-out (sub; 1 when a < b unsigned).
ovf  output  1  two's-complement signed overflow of the completed operation.

Behaviour:
- Reset: the block enters IDLE. ready=1, busy=0, done=0, result=0, cout_bout=0, ovf=0. Internal operand, counter and carry registers are cleared.
- States:
  - IDLE: ready=1. When start=1 at a clock edge, the block latches a, b and mode, clears the carry/borrow register and the bit counter, and goes to RUN.
  - RUN: each edge processes bit i, where i is the counter value 0..WIDTH-1.
  - After the edge that processes bit WIDTH-1, the block returns to IDLE.
- Per-bit logic, with c/br as the registered carry/borrow:
  - add: s = a_i^b_i^c; c' = a_i&b_i | c&(a_i^b_i).
  - sub: d = a_i^b_i^br; br' = ~a_i&b_i | ~(a_i^b_i)&br.
  - Result bits are shifted into a working register, MSB-side entry, LSB processed first.
- Latency:
  - start accepted at edge E0.
  - busy=1 from after E0 until edge E0+WIDTH.
  - At edge E0+WIDTH: result, cout_bout and ovf are updated together, done=1 for exactly one cycle, and ready returns to 1.
  - Total: WIDTH cycles from start to done.
- result, cout_bout and ovf change only at completion. They are stable at all other times, including during RUN.
- ovf rule, using MSBs of the latched operands and the final result:
  - add: a_msb==b_msb && r_msb!=a_msb.
  - sub: a_msb!=b_msb && r_msb!=a_msb.
- Boundary conditions:
  - start while busy=1 is ignored; operands are not re-latched.
  - start asserted in the done cycle (ready=1) is accepted, giving back-to-back operations with no idle gap.
  - Changes on a, b or mode after acceptance have no effect.
  - rst asserted mid-operation aborts it. No done pulse occurs, and all outputs take their reset values on that edge.
  - rst has priority over start in the same cycle.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, sub 0x05-0x03 -> result=0x02, cout_bout=0, ovf=0, done exactly 8 cycles after the start edge, single-cycle pulse.
- sub 0x03-0x05 -> result=0xFE, cout_bout=1, ovf=0; sub 0x80-0x01 -> result=0x7F, cout_bout=0, ovf=1.
- add 0xFF+0x01 -> result=0x00, cout_bout=1, ovf=0; add 0x7F+0x01 -> result=0x80, cout_bout=0, ovf=1.
- Busy/ignore check: start sub 0x10-0x01, re-assert start with add 0xAA+0x55 at cycle 3 -> only one done, result=0x0F. Next start in the done cycle is accepted, and its done arrives 8 cycles later.
- Reset mid-op: assert rst at cycle 4 of a run -> next cycle ready=1, result=0, flags=0, no done. A following op completes correctly.
- WIDTH=2 exhaustive: all 16 (a,b) pairs x both modes, checked against a reference model for result, cout_bout and ovf. This covers the half/full subtract truth table per bit.
